// File: rtl/variable_chooser_param.sv
// Uniform random variable chooser: an LFSR feeds rejection sampling over an
// eligibility mask. A deterministic fallback to the lowest eligible index
// caps the draw time. The result is held on a valid/ready handshake.
module variable_chooser_param #(
  parameter int NUM_BOOL  = 2,
  parameter int NUM_INT   = 3,
  parameter int IDX_W     = 8,
  parameter int LFSR_W    = 16,
  parameter int MAX_TRIES = 8
) (
  input  logic                         in_clock,
  input  logic                         in_reset_n,
  input  logic                         in_seed_load,
  input  logic [LFSR_W-1:0]            in_seed,
  input  logic                         in_request,
  input  logic [NUM_BOOL+NUM_INT-1:0]  in_eligible_mask,
  output logic                         out_valid,
  input  logic                         in_ready,
  output logic                         out_boolean_or_integer,
  output logic [IDX_W-1:0]             out_choosen_index,
  output logic [IDX_W-1:0]             out_general_index,
  output logic                         out_no_eligible,
  output logic                         out_busy
);

  localparam int TOTAL = NUM_BOOL + NUM_INT;
  localparam int GW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int MW    = 1 << GW;
  localparam int TW    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(32'h0000_B400);

  typedef enum logic [1:0] {IDLE, DRAW, PRESENT} state_t;

  state_t             state, state_d;
  logic [LFSR_W-1:0]  lfsr, lfsr_next;
  logic [TOTAL-1:0]   mask_q, mask_d;
  logic [TW-1:0]      tries_q, tries_d;
  logic [GW-1:0]      cand, fb_idx, pick;
  logic [MW-1:0]      mask_ext;
  logic               hit;
  logic [IDX_W-1:0]   pick_g, pick_loc;
  logic               pick_bool;
  logic [IDX_W-1:0]   gen_q, gen_d, loc_q, loc_d;
  logic               bool_q, bool_d, noel_q, noel_d;

  // Galois LFSR step; the candidate is the low bits of the next state
  always_comb lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);

  assign cand     = lfsr_next[GW-1:0];
  // Zero-extending the mask makes out-of-range candidates miss naturally
  assign mask_ext = MW'(mask_q);
  assign hit      = mask_ext[cand];

  // Lowest-numbered eligible index, used once the try budget is spent
  always_comb begin
    fb_idx = '0;
    for (int i = TOTAL - 1; i >= 0; i--)
      if (mask_q[i]) fb_idx = GW'(i);
  end

  // Split the chosen global index into type flag and type-local index
  always_comb begin
    pick      = hit ? cand : fb_idx;
    pick_g    = IDX_W'(pick);
    pick_bool = pick_g < IDX_W'(NUM_BOOL);
    pick_loc  = pick_bool ? pick_g : pick_g - IDX_W'(NUM_BOOL);
  end

  // Next-state and result computation
  always_comb begin
    state_d = state;
    mask_d  = mask_q;
    tries_d = tries_q;
    gen_d   = gen_q;
    loc_d   = loc_q;
    bool_d  = bool_q;
    noel_d  = noel_q;
    unique case (state)
      IDLE: begin
        if (in_request) begin
          mask_d  = in_eligible_mask;
          tries_d = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (mask_q == '0) begin
          noel_d  = 1'b1;
          gen_d   = '0;
          loc_d   = '0;
          bool_d  = 1'b0;
          state_d = PRESENT;
        end else if (hit || tries_q == TW'(MAX_TRIES - 1)) begin
          noel_d  = 1'b0;
          gen_d   = pick_g;
          loc_d   = pick_loc;
          bool_d  = pick_bool;
          state_d = PRESENT;
        end else begin
          tries_d = tries_q + TW'(1);
        end
      end
      PRESENT: begin
        if (in_ready) begin
          if (in_request) begin
            mask_d  = in_eligible_mask;
            tries_d = '0;
            state_d = DRAW;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, LFSR and result registers; seed load aborts any draw in flight
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state   <= IDLE;
      lfsr    <= LFSR_W'(1);
      mask_q  <= '0;
      tries_q <= '0;
      gen_q   <= '0;
      loc_q   <= '0;
      bool_q  <= 1'b0;
      noel_q  <= 1'b0;
    end else if (in_seed_load) begin
      lfsr  <= (in_seed == '0) ? LFSR_W'(1) : in_seed;
      state <= IDLE;
    end else begin
      state   <= state_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      gen_q   <= gen_d;
      loc_q   <= loc_d;
      bool_q  <= bool_d;
      noel_q  <= noel_d;
      if (state == DRAW) lfsr <= lfsr_next;
    end
  end

  assign out_valid              = (state == PRESENT);
  assign out_busy               = (state == DRAW);
  assign out_no_eligible        = noel_q && (state == PRESENT);
  assign out_general_index      = gen_q;
  assign out_choosen_index      = loc_q;
  assign out_boolean_or_integer = bool_q;

endmodule

// File: tb/tb_variable_chooser_param.sv
// Directed bench for variable_chooser_param with a scoreboard of predicted
// draws (result and latency) built from a reference LFSR model.
module tb_variable_chooser_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] seed;
  logic        request;
  logic [4:0]  mask;
  logic        valid;
  logic        ready;
  logic        bool_int;
  logic [7:0]  loc_idx;
  logic [7:0]  gen_idx;
  logic        no_elig;
  logic        busy;

  variable_chooser_param #(
    .NUM_BOOL(2), .NUM_INT(3), .IDX_W(8), .LFSR_W(16), .MAX_TRIES(8)
  ) dut (
    .in_clock(clk),
    .in_reset_n(rst_n),
    .in_seed_load(seed_load),
    .in_seed(seed),
    .in_request(request),
    .in_eligible_mask(mask),
    .out_valid(valid),
    .in_ready(ready),
    .out_boolean_or_integer(bool_int),
    .out_choosen_index(loc_idx),
    .out_general_index(gen_idx),
    .out_no_eligible(no_elig),
    .out_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gen;
    bit noel;
    int lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mlfsr;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          edges;
  int          cnt[8];

  function automatic logic [15:0] step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference draw: advances the model LFSR, returns result and edges to valid
  function automatic exp_t predict(input logic [4:0] m);
    exp_t e;
    int   tries;
    int   c;
    bit   done;
    e.gen = 0; e.noel = 1'b0; e.lat = 1;
    tries = 0; done = 1'b0;
    while (!done) begin
      mlfsr = step(mlfsr);
      e.lat++;
      c = int'(mlfsr[2:0]);
      if (m == 5'b0) begin
        e.noel = 1'b1; done = 1'b1;
      end else if (c < 5) begin
        if (m[c]) begin e.gen = c; done = 1'b1; end
      end
      if (!done) begin
        tries++;
        if (tries == 8) begin
          for (int i = 4; i >= 0; i--) if (m[i]) e.gen = i;
          done = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_load = 1'b1; seed = s;
    @(negedge clk);
    seed_load = 1'b0;
    mlfsr = (s == 16'h0) ? 16'h0001 : s;
  endtask

  // Called at a negedge; returns at the negedge after the request edge
  task automatic start(input logic [4:0] m, input bit b2b);
    mask = m; request = 1'b1;
    if (b2b) ready = 1'b1;
    sb.push_back(predict(m));
    @(negedge clk);
    request = 1'b0; ready = 1'b0;
    edges = 1;
  endtask

  task automatic wait_result();
    exp_t e;
    int   eg;
    while (valid !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    e = sb.pop_front();
    eg = e.noel ? 0 : e.gen;
    chk("valid", 32'(valid), 32'd1);
    chk("latency", edges, e.lat);
    chk("general", 32'(gen_idx), eg);
    chk("is_bool", 32'(bool_int), (!e.noel && eg < 2) ? 32'd1 : 32'd0);
    chk("local", 32'(loc_idx), (eg < 2) ? eg : eg - 2);
    chk("no_elig", 32'(no_elig), 32'(e.noel));
  endtask

  task automatic accept();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("idle_after_accept", 32'(valid), 32'd0);
  endtask

  initial begin
    logic [7:0] hold_gen;
    int         bad;
    rst_n = 1'b0; seed_load = 1'b0; seed = '0; request = 1'b0;
    mask = '0; ready = 1'b0;
    mlfsr = 16'h0001;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gen", 32'(gen_idx), 32'd0);
    chk("rst_noel", 32'(no_elig), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // first-try accept with all eligible
    load_seed(16'h0001);
    start(5'b11111, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_result();
    chk("t1_lat", edges, 2);
    chk("t1_gen", 32'(gen_idx), 32'd0);
    accept();

    // eight rejections of candidate 0, fallback to index 1
    load_seed(16'h0001);
    start(5'b11110, 1'b0);
    wait_result();
    chk("t2_lat", edges, 9);
    chk("t2_gen", 32'(gen_idx), 32'd1);
    accept();

    // empty mask
    start(5'b00000, 1'b0);
    wait_result();
    chk("t3_noel", 32'(no_elig), 32'd1);
    accept();

    // backpressure, then back-to-back request
    start(5'b11111, 1'b0);
    wait_result();
    hold_gen = gen_idx;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (valid !== 1'b1 || gen_idx !== hold_gen) bad++;
    end
    chk("t4_stable", bad, 0);
    start(5'b11100, 1'b1);
    chk("t4_b2b_busy", 32'(busy), 32'd1);
    chk("t4_b2b_valid", 32'(valid), 32'd0);
    wait_result();
    accept();

    // zero seed becomes 1
    load_seed(16'h0000);
    start(5'b11111, 1'b0);
    wait_result();
    chk("t5_gen", 32'(gen_idx), 32'd0);
    accept();

    // seed load aborts a draw in flight
    load_seed(16'h0001);
    start(5'b11110, 1'b0);
    void'(sb.pop_back());
    load_seed(16'h1234);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid !== 1'b0) bad++;
    end
    chk("t5_abort_valid", bad, 0);
    start(5'b11111, 1'b0);
    wait_result();
    accept();

    // asynchronous reset mid-draw
    load_seed(16'h0001);
    start(5'b11110, 1'b0);
    void'(sb.pop_back());
    #2 rst_n = 1'b0;
    #1 chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mlfsr = 16'h0001;
    start(5'b11111, 1'b0);
    wait_result();
    chk("arst_gen", 32'(gen_idx), 32'd0);
    accept();

    // distribution over back-to-back draws
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    load_seed(16'hACE1);
    start(5'b11111, 1'b0);
    for (int k = 0; k < 8000; k++) begin
      wait_result();
      cnt[gen_idx[2:0]]++;
      if (k < 7999) start(5'b11111, 1'b1);
      else accept();
    end
    for (int i = 0; i < 5; i++)
      chk("dist_in_band", 32'((cnt[i] >= 1400) && (cnt[i] <= 1800)), 32'd1);
    chk("dist_out_range", cnt[5] + cnt[6] + cnt[7], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
